// File: rtl/bus_arbiter_mux_if.sv
// Shared-bus arbiter interface: source requests in, registered bus out.
// The master side drives requests; the arbiter sits on the slave side.
interface bus_arbiter_mux_if #(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int CNT_W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_en;
  logic           lock;
  logic           clr_cnt;
  logic [W-1:0]   bus;
  logic           bus_valid;
  logic [N-1:0]   grant;
  logic [IW-1:0]  grant_idx;
  logic           contention;
  logic [CNT_W-1:0] contention_cnt;

  modport master (
    output src_data, src_en, lock, clr_cnt,
    input  bus, bus_valid, grant, grant_idx,
    input  contention, contention_cnt
  );

  modport slave (
    input  src_data, src_en, lock, clr_cnt,
    output bus, bus_valid, grant, grant_idx,
    output contention, contention_cnt
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered N-source bus arbiter/mux with fixed or round-robin priority,
// grant locking, idle hold and a saturating contention counter.
module bus_arbiter_mux #(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int RR    = 0,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  bus_arbiter_mux_if.slave bif
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]     bus_q;
  logic             valid_q;
  logic [N-1:0]     grant_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    last_q;
  logic             cont_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IW-1:0] win;
  logic          hit;
  logic          locked;
  logic          cont;

  always_comb begin
    win    = '0;
    hit    = 1'b0;
    locked = bif.lock && (|grant_q) && bif.src_en[idx_q];
    if (locked) begin
      win = idx_q;
      hit = 1'b1;
    end else if (RR == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (bif.src_en[i]) begin
          win = IW'(i);
          hit = 1'b1;
        end
      end
    end else begin
      // Walk forward from the slot after the previous winner.
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (int'(last_q) + k) % N;
        if (!hit && bif.src_en[j]) begin
          win = IW'(j);
          hit = 1'b1;
        end
      end
    end
  end

  assign cont = ($countones(bif.src_en) >= 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(N - 1);
    end else if (hit) begin
      bus_q   <= bif.src_data[win*W +: W];
      valid_q <= 1'b1;
      grant_q <= N'(1) << win;
      idx_q   <= win;
      last_q  <= win;
    end else begin
      valid_q <= 1'b0;
      grant_q <= '0;
      if (HOLD == 0) bus_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cont_q <= cont;
      if (bif.clr_cnt)
        cnt_q <= '0;
      else if (cont && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bif.bus            = bus_q;
  assign bif.bus_valid      = valid_q;
  assign bif.grant          = grant_q;
  assign bif.grant_idx      = idx_q;
  assign bif.contention     = cont_q;
  assign bif.contention_cnt = cnt_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench: fixed, round-robin, saturating and non-holding
// arbiter instances driven with hand-computed vectors.
module tb_bus_arbiter_mux;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bus_arbiter_mux_if #(.N(5), .W(8), .CNT_W(8)) fi ();
  bus_arbiter_mux_if #(.N(5), .W(8), .CNT_W(8)) ri ();
  bus_arbiter_mux_if #(.N(5), .W(8), .CNT_W(2)) si ();
  bus_arbiter_mux_if #(.N(5), .W(8), .CNT_W(8)) hi ();

  bus_arbiter_mux #(.N(5), .W(8), .RR(0), .HOLD(1), .CNT_W(8))
    u_fix (.clk(clk), .rst_n(rst_n), .bif(fi.slave));
  bus_arbiter_mux #(.N(5), .W(8), .RR(1), .HOLD(1), .CNT_W(8))
    u_rr (.clk(clk), .rst_n(rst_n), .bif(ri.slave));
  bus_arbiter_mux #(.N(5), .W(8), .RR(1), .HOLD(1), .CNT_W(2))
    u_sat (.clk(clk), .rst_n(rst_n), .bif(si.slave));
  bus_arbiter_mux #(.N(5), .W(8), .RR(0), .HOLD(0), .CNT_W(8))
    u_nohold (.clk(clk), .rst_n(rst_n), .bif(hi.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fi.bus !== 8'h00) begin
      n_err++;
      $display("FAIL reset_bus got %h want 00", fi.bus);
    end
    n_cmp++;
    if (fi.bus_valid !== 1'b0 || fi.grant !== 5'b0) begin
      n_err++;
      $display("FAIL reset_grant got %b/%b want 0/00000",
               fi.bus_valid, fi.grant);
    end
    n_cmp++;
    if (fi.grant_idx !== 3'd0 || fi.contention !== 1'b0 ||
        fi.contention_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_idx_cnt got %0d/%b/%0d want 0/0/0",
               fi.grant_idx, fi.contention, fi.contention_cnt);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    fi.src_data[2*8 +: 8] = 8'h3C;
    fi.src_en = 5'b00100;
    cyc();
    n_cmp++;
    if (fi.bus !== 8'h3C || fi.bus_valid !== 1'b1) begin
      n_err++;
      $display("FAIL single_bus got %h/%b want 3c/1",
               fi.bus, fi.bus_valid);
    end
    n_cmp++;
    if (fi.grant !== 5'b00100 || fi.grant_idx !== 3'd2 ||
        fi.contention !== 1'b0) begin
      n_err++;
      $display("FAIL single_grant got %b/%0d/%b want 00100/2/0",
               fi.grant, fi.grant_idx, fi.contention);
    end
    fi.src_en = 5'b0;
    cyc();
    n_cmp++;
    if (fi.bus !== 8'h3C || fi.bus_valid !== 1'b0 ||
        fi.grant !== 5'b0 || fi.grant_idx !== 3'd2) begin
      n_err++;
      $display("FAIL single_idle got %h/%b/%b/%0d want 3c/0/00000/2",
               fi.bus, fi.bus_valid, fi.grant, fi.grant_idx);
    end
  endtask

  task automatic test_fixed_contention();
    fi.src_data[1*8 +: 8] = 8'h11;
    fi.src_data[2*8 +: 8] = 8'h22;
    fi.src_data[4*8 +: 8] = 8'h44;
    fi.src_en = 5'b10110;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_cmp++;
      if (fi.bus !== 8'h11 || fi.contention !== 1'b1 ||
          fi.contention_cnt !== 8'(c + 1)) begin
        n_err++;
        $display("FAIL fixed_cont[%0d] got %h/%b/%0d want 11/1/%0d",
                 c, fi.bus, fi.contention, fi.contention_cnt, c + 1);
      end
    end
    fi.clr_cnt = 1'b1;
    cyc();
    n_cmp++;
    if (fi.contention_cnt !== 8'd0 || fi.contention !== 1'b1) begin
      n_err++;
      $display("FAIL fixed_clr got %0d/%b want 0/1",
               fi.contention_cnt, fi.contention);
    end
    fi.clr_cnt = 1'b0;
    cyc();
    n_cmp++;
    if (fi.contention_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL fixed_after_clr got %0d want 1",
               fi.contention_cnt);
    end
    fi.src_en = 5'b0;
    cyc();
  endtask

  task automatic test_rr_rotation();
    logic [2:0] exp_a [6];
    logic [2:0] exp_b [4];
    exp_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    exp_b = '{3'd1, 3'd3, 3'd1, 3'd3};
    for (int i = 0; i < 5; i++) ri.src_data[i*8 +: 8] = 8'hA0 + 8'(i);
    ri.src_en = 5'b11111;
    for (int c = 0; c < 6; c++) begin
      cyc();
      n_cmp++;
      if (ri.grant_idx !== exp_a[c] ||
          ri.bus !== 8'hA0 + 8'(exp_a[c])) begin
        n_err++;
        $display("FAIL rr_all[%0d] got %0d/%h want %0d",
                 c, ri.grant_idx, ri.bus, exp_a[c]);
      end
    end
    ri.src_en = 5'b01010;
    for (int c = 0; c < 4; c++) begin
      cyc();
      n_cmp++;
      if (ri.grant_idx !== exp_b[c]) begin
        n_err++;
        $display("FAIL rr_pair[%0d] got %0d want %0d",
                 c, ri.grant_idx, exp_b[c]);
      end
    end
  endtask

  task automatic test_lock();
    ri.lock = 1'b1;
    ri.src_en = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      ri.src_data[3*8 +: 8] = 8'h30 + 8'(c);
      cyc();
      n_cmp++;
      if (ri.grant !== 5'b01000 || ri.bus !== 8'h30 + 8'(c)) begin
        n_err++;
        $display("FAIL lock_hold[%0d] got %b/%h want 01000/%h",
                 c, ri.grant, ri.bus, 8'h30 + 8'(c));
      end
    end
    ri.src_en = 5'b10111;
    cyc();
    n_cmp++;
    if (ri.grant !== 5'b10000 || ri.grant_idx !== 3'd4 ||
        ri.bus !== 8'hA4) begin
      n_err++;
      $display("FAIL lock_drop got %b/%0d/%h want 10000/4/a4",
               ri.grant, ri.grant_idx, ri.bus);
    end
    ri.src_en = 5'b0;
    cyc();
    n_cmp++;
    if (ri.grant !== 5'b0 || ri.bus_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lock_idle got %b/%b want 00000/0",
               ri.grant, ri.bus_valid);
    end
    ri.src_en = 5'b00101;
    cyc();
    n_cmp++;
    if (ri.grant_idx !== 3'd0 || ri.grant !== 5'b00001) begin
      n_err++;
      $display("FAIL lock_after_idle got %0d/%b want 0/00001",
               ri.grant_idx, ri.grant);
    end
    ri.lock = 1'b0;
    ri.src_en = 5'b0;
    cyc();
  endtask

  task automatic test_saturation_reset();
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) si.src_data[i*8 +: 8] = 8'h50 + 8'(i);
    si.src_en = 5'b11111;
    for (int c = 0; c < 5; c++) begin
      cyc();
      n_cmp++;
      if (si.contention_cnt !== exp_c[c]) begin
        n_err++;
        $display("FAIL sat_cnt[%0d] got %0d want %0d",
                 c, si.contention_cnt, exp_c[c]);
      end
    end
    si.src_en = 5'b00100;
    cyc();
    n_cmp++;
    if (si.grant_idx !== 3'd2 || si.contention_cnt !== 2'd3) begin
      n_err++;
      $display("FAIL sat_single got %0d/%0d want 2/3",
               si.grant_idx, si.contention_cnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (si.bus !== 8'h00 || si.grant !== 5'b0 ||
        si.contention_cnt !== 2'd0 || si.bus_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got %h/%b/%0d/%b want 00/00000/0/0",
               si.bus, si.grant, si.contention_cnt, si.bus_valid);
    end
    si.src_en = 5'b01010;
    #1;
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (si.grant_idx !== 3'd1 || si.bus !== 8'h51) begin
      n_err++;
      $display("FAIL post_reset_rr got %0d/%h want 1/51",
               si.grant_idx, si.bus);
    end
    si.src_en = 5'b0;
  endtask

  task automatic test_hold0();
    hi.src_data[0 +: 8] = 8'hA5;
    hi.src_en = 5'b00001;
    cyc();
    n_cmp++;
    if (hi.bus !== 8'hA5 || hi.bus_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold0_grant got %h/%b want a5/1",
               hi.bus, hi.bus_valid);
    end
    hi.src_en = 5'b0;
    cyc();
    n_cmp++;
    if (hi.bus !== 8'h00 || hi.bus_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold0_idle got %h/%b want 00/0",
               hi.bus, hi.bus_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    fi.src_data = '0; fi.src_en = '0; fi.lock = 1'b0; fi.clr_cnt = 1'b0;
    ri.src_data = '0; ri.src_en = '0; ri.lock = 1'b0; ri.clr_cnt = 1'b0;
    si.src_data = '0; si.src_en = '0; si.lock = 1'b0; si.clr_cnt = 1'b0;
    hi.src_data = '0; hi.src_en = '0; hi.lock = 1'b0; hi.clr_cnt = 1'b0;
    test_reset();
    test_single();
    test_fixed_contention();
    test_rr_rotation();
    test_lock();
    test_saturation_reset();
    test_hold0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
